// File: rtl/dpmem_be.sv
`default_nettype none
// ============================================================================
//  Module      : dpmem_be
//  Description : Single-clock true dual-port RAM with per-port byte-write
//                enables, a per-port read-during-write mode (read-first,
//                write-first, no-change), per-port output valid, an optional
//                per-port output register and a registered address-collision
//                flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1      rising-edge clock
//    rst_n  in   1      asynchronous active-low reset (output/valid regs only)
//    ena    in   1      port A enable
//    wea    in   NB     port A byte-write enables (bit i -> lane i)
//    addra  in   DEPTH  port A address
//    dia    in   WIDTH  port A write data
//    doa    out  WIDTH  port A read data
//    vala   out  1      doa holds data for an enabled port A access
//    enb/web/addrb/dib/dob/valb   port B, same meaning
//    coll   out  1      one-cycle pulse: same-address access with a write
// ============================================================================
module dpmem_be #(
    parameter int DEPTH   = 10,
    parameter int WIDTH   = 32,
    parameter int BYTEW   = 8,
    parameter int MODEA   = 0,
    parameter int MODEB   = 0,
    parameter int OUTREGA = 1,
    parameter int OUTREGB = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [WIDTH/BYTEW-1:0]   wea,
    input  logic [DEPTH-1:0]         addra,
    input  logic [WIDTH-1:0]         dia,
    output logic [WIDTH-1:0]         doa,
    output logic                     vala,
    input  logic                     enb,
    input  logic [WIDTH/BYTEW-1:0]   web,
    input  logic [DEPTH-1:0]         addrb,
    input  logic [WIDTH-1:0]         dib,
    output logic [WIDTH-1:0]         dob,
    output logic                     valb,
    output logic                     coll
);

    localparam int NB     = WIDTH / BYTEW;
    localparam int NWORDS = 1 << DEPTH;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (WIDTH % BYTEW != 0) begin : g_err_width
            $error("dpmem_be: WIDTH must be a multiple of BYTEW");
        end
        if (MODEA > 2 || MODEA < 0) begin : g_err_modea
            $error("dpmem_be: MODEA must be 0, 1 or 2");
        end
        if (MODEB > 2 || MODEB < 0) begin : g_err_modeb
            $error("dpmem_be: MODEB must be 0, 1 or 2");
        end
    endgenerate

    // Replace the lanes selected by lane_we with new data.
    function automatic logic [WIDTH-1:0] merge_word(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    lane_we
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                res[i*BYTEW +: BYTEW] = new_w[i*BYTEW +: BYTEW];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Storage array (never reset)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [NWORDS];

    // Port B is committed first so that port A's assignment to a lane
    // written by both ports in the same cycle is the one that sticks.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (enb && web[i]) begin
                mem[addrb][i*BYTEW +: BYTEW] <= dib[i*BYTEW +: BYTEW];
            end
            if (ena && wea[i]) begin
                mem[addra][i*BYTEW +: BYTEW] <= dia[i*BYTEW +: BYTEW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port read paths; index 0 = port A, 1 = port B
    // ------------------------------------------------------------------
    logic [1:0]              en;
    logic [1:0][NB-1:0]      we;
    logic [1:0][DEPTH-1:0]   addr;
    logic [1:0][WIDTH-1:0]   din;
    logic [1:0][WIDTH-1:0]   dout;
    logic [1:0]              vout;

    assign en   = {enb, ena};
    assign we   = {web, wea};
    assign addr = {addrb, addra};
    assign din  = {dib, dia};

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            localparam int MODE = (p == 0) ? MODEA : MODEB;
            localparam int OREG = (p == 0) ? OUTREGA : OUTREGB;

            logic [WIDTH-1:0] old_word;
            logic [WIDTH-1:0] d1_d, d1_q;
            logic             v1_d, v1_q;

            // Pre-edge content: the other port's same-cycle write is never
            // visible here, only this port's own write (write-first) is.
            assign old_word = mem[addr[p]];

            always_comb begin
                d1_d = d1_q;
                v1_d = en[p];
                if (en[p]) begin
                    if (MODE == 1) begin
                        d1_d = merge_word(old_word, din[p], we[p]);
                    end else if (MODE == 0 || we[p] == '0) begin
                        d1_d = old_word;
                    end
                    // no-change mode with a write: data holds, valid pulses
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d1_q <= '0;
                    v1_q <= 1'b0;
                end else begin
                    d1_q <= d1_d;
                    v1_q <= v1_d;
                end
            end

            if (OREG != 0) begin : g_oreg
                logic [WIDTH-1:0] d2_d, d2_q;
                logic             v2_d, v2_q;

                always_comb begin
                    d2_d = d2_q;
                    v2_d = v1_q;
                    if (v1_q) begin
                        d2_d = d1_q;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        d2_q <= '0;
                        v2_q <= 1'b0;
                    end else begin
                        d2_q <= d2_d;
                        v2_q <= v2_d;
                    end
                end

                assign dout[p] = d2_q;
                assign vout[p] = v2_q;
            end else begin : g_noreg
                assign dout[p] = d1_q;
                assign vout[p] = v1_q;
            end
        end
    endgenerate

    assign doa  = dout[0];
    assign vala = vout[0];
    assign dob  = dout[1];
    assign valb = vout[1];

    // ------------------------------------------------------------------
    // Collision flag: same address on both enabled ports with any write
    // ------------------------------------------------------------------
    logic coll_d, coll_q;

    always_comb begin
        coll_d = ena & enb & (addra == addrb) & ((|wea) | (|web));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign coll = coll_q;

endmodule
`default_nettype wire

// File: tb/tb_dpmem_be.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpmem_be
//  Description : Self-checking bench for dpmem_be. Two instances with
//                different mode / output-register settings share one
//                stimulus stream and one behavioural model of the array.
//                u0: A read-first + out reg, B write-first, no out reg
//                u1: A no-change, no out reg, B no-change + out reg
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpmem_be;

    localparam int DW  = 4;
    localparam int W   = 32;
    localparam int NBL = 4;
    localparam int ND  = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena   = 1'b0;
    logic          enb   = 1'b0;
    logic [3:0]    wea   = '0;
    logic [3:0]    web   = '0;
    logic [DW-1:0] addra = '0;
    logic [DW-1:0] addrb = '0;
    logic [W-1:0]  dia   = '0;
    logic [W-1:0]  dib   = '0;

    logic [W-1:0]  doa0, dob0, doa1, dob1;
    logic          vala0, valb0, coll0, vala1, valb1, coll1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dpmem_be #(.DEPTH(DW), .WIDTH(W), .BYTEW(8), .MODEA(0), .MODEB(1),
               .OUTREGA(1), .OUTREGB(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa0), .vala(vala0),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob0), .valb(valb0),
        .coll(coll0));

    dpmem_be #(.DEPTH(DW), .WIDTH(W), .BYTEW(8), .MODEA(2), .MODEB(2),
               .OUTREGA(0), .OUTREGB(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa1), .vala(vala1),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob1), .valb(valb1),
        .coll(coll1));

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int mode [2][2] = '{'{0, 1}, '{2, 2}};
    int oreg [2][2] = '{'{1, 0}, '{0, 1}};

    logic [W-1:0]   mm [ND];       // array contents
    logic [NBL-1:0] mk [ND];       // which lanes hold defined data
    logic [W-1:0]   s1d [2][2];
    logic [W-1:0]   s2d [2][2];
    logic [NBL-1:0] s1k [2][2];
    logic [NBL-1:0] s2k [2][2];
    logic           s1v [2][2];
    logic           s2v [2][2];
    logic           ecoll [2];

    logic           m_en [2];
    logic [3:0]     m_we [2];
    logic [DW-1:0]  m_ad [2];
    logic [W-1:0]   m_di [2];
    logic [W-1:0]   m_old;
    logic [NBL-1:0] m_oldk;
    logic           m_coll;

    function automatic logic [W-1:0] lane_mask(input logic [NBL-1:0] m);
        logic [W-1:0] r;
        for (int l = 0; l < NBL; l++) r[l*8 +: 8] = {8{m[l]}};
        return r;
    endfunction

    initial begin
        for (int i = 0; i < ND; i++) begin
            mm[i] = '0;
            mk[i] = '0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    s1d[k][p] = '0; s1k[k][p] = '1; s1v[k][p] = 1'b0;
                    s2d[k][p] = '0; s2k[k][p] = '1; s2v[k][p] = 1'b0;
                end
                ecoll[k] = 1'b0;
            end
        end else begin
            m_en[0] = ena; m_we[0] = wea; m_ad[0] = addra; m_di[0] = dia;
            m_en[1] = enb; m_we[1] = web; m_ad[1] = addrb; m_di[1] = dib;
            m_coll  = ena && enb && (addra == addrb) && (wea != 0 || web != 0);
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (s1v[k][p]) begin
                        s2d[k][p] = s1d[k][p];
                        s2k[k][p] = s1k[k][p];
                    end
                    s2v[k][p] = s1v[k][p];
                    if (m_en[p]) begin
                        m_old  = mm[m_ad[p]];
                        m_oldk = mk[m_ad[p]];
                        if (mode[k][p] == 0) begin
                            s1d[k][p] = m_old;
                            s1k[k][p] = m_oldk;
                        end else if (mode[k][p] == 1) begin
                            s1d[k][p] = (m_old & ~lane_mask(m_we[p])) |
                                        (m_di[p] & lane_mask(m_we[p]));
                            s1k[k][p] = m_oldk | m_we[p];
                        end else if (m_we[p] == 0) begin
                            s1d[k][p] = m_old;
                            s1k[k][p] = m_oldk;
                        end
                    end
                    s1v[k][p] = m_en[p];
                end
                ecoll[k] = m_coll;
            end
            // commit: B first, A last so A owns doubly-written lanes
            for (int p = 1; p >= 0; p--) begin
                if (m_en[p]) begin
                    mm[m_ad[p]] = (mm[m_ad[p]] & ~lane_mask(m_we[p])) |
                                  (m_di[p] & lane_mask(m_we[p]));
                    mk[m_ad[p]] = mk[m_ad[p]] | m_we[p];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] act_do(input int k, input int p);
        if (k == 0) return (p == 0) ? doa0 : dob0;
        return (p == 0) ? doa1 : dob1;
    endfunction

    function automatic logic act_v(input int k, input int p);
        if (k == 0) return (p == 0) ? vala0 : valb0;
        return (p == 0) ? vala1 : valb1;
    endfunction

    logic [W-1:0] c_ed, c_em, c_ad;
    logic         c_ev;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    c_ed = (oreg[k][p] != 0) ? s2d[k][p] : s1d[k][p];
                    c_em = lane_mask((oreg[k][p] != 0) ? s2k[k][p] : s1k[k][p]);
                    c_ev = (oreg[k][p] != 0) ? s2v[k][p] : s1v[k][p];
                    c_ad = act_do(k, p);
                    n_cmp++;
                    if ((c_ad & c_em) !== (c_ed & c_em)) begin
                        n_bad++;
                        $display("FAIL u%0d do%s t=%0t: got %h expected %h (lane mask %h)",
                                 k, (p == 0) ? "a" : "b", $time, c_ad, c_ed, c_em);
                    end
                    n_cmp++;
                    if (act_v(k, p) !== c_ev) begin
                        n_bad++;
                        $display("FAIL u%0d val%s t=%0t: got %b expected %b",
                                 k, (p == 0) ? "a" : "b", $time, act_v(k, p), c_ev);
                    end
                end
            end
            n_cmp++;
            if (coll0 !== ecoll[0] || coll1 !== ecoll[1]) begin
                n_bad++;
                $display("FAIL coll t=%0t: got %b/%b expected %b/%b",
                         $time, coll0, coll1, ecoll[0], ecoll[1]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed literal checks and stimulus helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask

    task automatic acc_a(input logic [DW-1:0] a, input logic [3:0] w, input logic [W-1:0] d);
        ena = 1'b1; addra = a; wea = w; dia = d;
    endtask

    task automatic acc_b(input logic [DW-1:0] a, input logic [3:0] w, input logic [W-1:0] d);
        enb = 1'b1; addrb = a; web = w; dib = d;
    endtask

    initial begin
        // reset then idle
        #2;
        rst_n  = 1'b0;
        chk_en = 1'b1;
        repeat (3) cyc();
        chk("rst doa0", doa0, 32'h0);
        chk("rst vala0", {31'b0, vala0}, 32'h0);
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("idle doa0", doa0, 32'h0);
        chk("idle dob1", dob1, 32'h0);
        chk("idle valid/coll", {27'b0, vala0, valb0, vala1, valb1, coll0}, 32'h0);

        // byte-enable merge
        acc_a(4'd1, 4'hF, 32'h11223344); cyc();
        acc_a(4'd1, 4'h2, 32'h0000AA00); cyc();
        acc_a(4'd1, 4'h0, 32'h0);        cyc();
        idle();
        chk("u1 doa read addr1", doa1, 32'h1122AA44);
        chk("u0 doa read-first prior", doa0, 32'h11223344);
        cyc();
        chk("u0 doa merge", doa0, 32'h1122AA44);
        chk("u0 vala merge", {31'b0, vala0}, 32'h1);
        cyc();
        chk("u0 vala drained", {31'b0, vala0}, 32'h0);

        // read-first vs write-first
        acc_a(4'd2, 4'hF, 32'h55667788); acc_b(4'd3, 4'hF, 32'h01020304); cyc();
        acc_a(4'd2, 4'hF, 32'hCAFEDECA); acc_b(4'd3, 4'h3, 32'hDEADBEEF); cyc();
        idle();
        chk("u0 dob write-first", dob0, 32'h0102BEEF);
        chk("u1 doa no-change hold", doa1, 32'h1122AA44);
        chk("u1 vala no-change", {31'b0, vala1}, 32'h1);
        cyc();
        chk("u0 doa read-first", doa0, 32'h55667788);
        cyc();

        // no-change on u1 port B (latency 2)
        acc_b(4'd4, 4'hF, 32'h12345678); cyc(); idle();
        acc_b(4'd4, 4'h0, 32'h0);        cyc(); idle(); cyc();
        chk("u1 dob read", dob1, 32'h12345678);
        acc_b(4'd4, 4'hF, 32'h00000009); cyc(); idle();
        chk("u0 dob write-first 9", dob0, 32'h00000009);
        cyc();
        chk("u1 dob no-change", dob1, 32'h12345678);
        chk("u1 valb no-change", {31'b0, valb1}, 32'h1);
        acc_b(4'd4, 4'h0, 32'h0); cyc(); idle(); cyc();
        chk("u1 dob after write", dob1, 32'h00000009);

        // collision
        acc_a(4'd5, 4'hF, 32'hAAAAAAAA); acc_b(4'd5, 4'hC, 32'hBBBBBBBB); cyc(); idle();
        chk("coll pulse", {30'b0, coll0, coll1}, 32'h3);
        cyc();
        chk("coll single", {30'b0, coll0, coll1}, 32'h0);
        acc_a(4'd5, 4'h0, 32'h0); cyc(); idle(); cyc();
        chk("coll A wins", doa0, 32'hAAAAAAAA);
        acc_a(4'd5, 4'h3, 32'hAAAAAAAA); acc_b(4'd5, 4'hC, 32'hBBBBBBBB); cyc(); idle();
        chk("coll pulse 2", {31'b0, coll0}, 32'h1);
        chk("u0 dob own view", dob0, 32'hBBBBAAAA);
        cyc();
        acc_a(4'd5, 4'h0, 32'h0); cyc(); idle(); cyc();
        chk("coll lane split", doa0, 32'hBBBBAAAA);

        // reset between access edge and output edge
        acc_a(4'd1, 4'h0, 32'h0); cyc(); idle();
        rst_n = 1'b0;
        #1;
        chk("midrst doa0", doa0, 32'h0);
        chk("midrst vala0", {31'b0, vala0}, 32'h0);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("postrst vala0", {31'b0, vala0}, 32'h0);
        chk("postrst doa0", doa0, 32'h0);
        acc_a(4'd1, 4'h0, 32'h0); cyc(); idle(); cyc();
        chk("postrst data", doa0, 32'h1122AA44);
        chk("postrst vala", {31'b0, vala0}, 32'h1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle();
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end else begin
                ena   = ($urandom_range(0, 3) != 0);
                wea   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                addra = DW'($urandom);
                dia   = $urandom;
                enb   = ($urandom_range(0, 3) != 0);
                web   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                addrb = ($urandom_range(0, 3) == 0) ? addra : DW'($urandom);
                dib   = $urandom;
                cyc();
            end
        end
        idle();
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
